rvsteel_spi_target: RTL and testbench



---
 rtl/rvsteel_spi_target.sv | 155 +++++++++++++++
 tb/tb_rvsteel_spi_target.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvsteel_spi_target.sv
// SPI target: oversamples sclk/pico/cs in the system clock domain and moves 8-bit MSB-first
// frames between the pins and a one-entry TX holding register / one-entry RX register.
module rvsteel_spi_target #(
  parameter bit         CPOL       = 1'b0,
  parameter bit         CPHA       = 1'b0,
  parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sclk,
  input  logic       pico,
  input  logic       cs,
  output logic       poci,
  output logic       poci_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic       tx_underrun,
  output logic       busy
);

  logic       sclk_s1, sclk_s2, sclk_q;
  logic       pico_s1, pico_s2;
  logic       cs_s1, cs_s2, cs_q;
  logic [1:0] settle_q;
  logic       armed_q;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] hold_q;
  logic       hold_full_q;

  logic       lead_edge, trail_edge, sample_edge, shift_edge;
  logic       cs_fall, cs_rise, select, deselect, complete, load;
  logic [7:0] load_byte;
  logic       load_underrun, hold_wr;

  assign tx_ready = ~hold_full_q;
  assign poci_oe  = busy;

  always_comb begin
    lead_edge   = (sclk_q == CPOL) && (sclk_s2 != CPOL);
    trail_edge  = (sclk_q != CPOL) && (sclk_s2 == CPOL);
    sample_edge = CPHA ? trail_edge : lead_edge;
    shift_edge  = CPHA ? lead_edge : trail_edge;

    cs_fall  = cs_q && !cs_s2;
    cs_rise  = !cs_q && cs_s2;
    // armed_q blocks a false SELECT when cs is already low as reset releases
    select   = cs_fall && armed_q && !busy;
    deselect = cs_rise && busy;
    complete = busy && !deselect && sample_edge && (bit_cnt == 3'd7);
    load     = select || complete;

    load_underrun = 1'b0;
    if (hold_full_q) begin
      load_byte = hold_q;
    end else if (tx_valid) begin
      load_byte = tx_data;
    end else begin
      load_byte     = DEFAULT_TX;
      load_underrun = load;
    end

    // A bypassed byte goes straight to tx_shift and must not also fill the holding register
    hold_wr = tx_valid && !hold_full_q && !load;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sclk_s1     <= CPOL;
      sclk_s2     <= CPOL;
      sclk_q      <= CPOL;
      pico_s1     <= 1'b0;
      pico_s2     <= 1'b0;
      cs_s1       <= 1'b1;
      cs_s2       <= 1'b1;
      cs_q        <= 1'b1;
      settle_q    <= 2'd0;
      armed_q     <= 1'b0;
      busy        <= 1'b0;
      bit_cnt     <= 3'd0;
      rx_shift    <= 8'h00;
      tx_shift    <= 8'h00;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      poci        <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_q  <= sclk_s2;
      pico_s1 <= pico;
      pico_s2 <= pico_s1;
      cs_s1   <= cs;
      cs_s2   <= cs_s1;
      cs_q    <= cs_s2;

      // Wait for the synchronizers to carry the real pin level before arming on cs high
      if (settle_q != 2'd3) begin
        settle_q <= settle_q + 2'd1;
      end else if (cs_s2) begin
        armed_q <= 1'b1;
      end

      rx_overrun  <= 1'b0;
      tx_underrun <= load_underrun;

      if (hold_wr) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end else if (load && hold_full_q) begin
        hold_full_q <= 1'b0;
      end

      if (complete) begin
        rx_data    <= {rx_shift[6:0], pico_s2};
        rx_valid   <= 1'b1;
        rx_overrun <= rx_valid && !rx_ready;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (deselect) begin
        busy    <= 1'b0;
        bit_cnt <= 3'd0;
      end else if (select) begin
        busy     <= 1'b1;
        bit_cnt  <= 3'd0;
        tx_shift <= load_byte;
      end else if (busy) begin
        if (sample_edge) begin
          rx_shift <= {rx_shift[6:0], pico_s2};
          bit_cnt  <= bit_cnt + 3'd1;
          if (complete) begin
            tx_shift <= load_byte;
          end
        end else if (shift_edge && (bit_cnt != 3'd0)) begin
          // At count 0 the MSB is already on poci, so the first shift edge is skipped
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end

      poci <= (busy && !deselect) ? tx_shift[7] : 1'b0;
    end
  end

endmodule

// File: tb/tb_rvsteel_spi_target.sv
// Directed bench: a mode-0 and a mode-3 instance driven by a clock/8 SPI controller model.
module tb_rvsteel_spi_target;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sclk0 = 1'b0;
  logic       sclk3 = 1'b1;
  logic       cs0 = 1'b1;
  logic       cs3 = 1'b1;
  logic       pico = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid0 = 1'b0;
  logic       tx_valid3 = 1'b0;
  logic       rx_ready = 1'b0;

  logic       poci0, poci_oe0, tx_ready0, rx_valid0, rx_overrun0, tx_underrun0, busy0;
  logic       poci3, poci_oe3, tx_ready3, rx_valid3, rx_overrun3, tx_underrun3, busy3;
  logic [7:0] rx_data0, rx_data3;

  int tests = 0;
  int fails = 0;
  int ovr0 = 0, und0 = 0, ovr3 = 0, und3 = 0;

  rvsteel_spi_target #(.CPOL(1'b0), .CPHA(1'b0), .DEFAULT_TX(8'hFF)) dut0 (
    .clock(clock), .reset(reset), .sclk(sclk0), .pico(pico), .cs(cs0), .poci(poci0),
    .poci_oe(poci_oe0), .tx_data(tx_data), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready), .rx_overrun(rx_overrun0),
    .tx_underrun(tx_underrun0), .busy(busy0)
  );

  rvsteel_spi_target #(.CPOL(1'b1), .CPHA(1'b1), .DEFAULT_TX(8'hFF)) dut3 (
    .clock(clock), .reset(reset), .sclk(sclk3), .pico(pico), .cs(cs3), .poci(poci3),
    .poci_oe(poci_oe3), .tx_data(tx_data), .tx_valid(tx_valid3), .tx_ready(tx_ready3),
    .rx_data(rx_data3), .rx_valid(rx_valid3), .rx_ready(rx_ready), .rx_overrun(rx_overrun3),
    .tx_underrun(tx_underrun3), .busy(busy3)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (rx_overrun0)  ovr0++;
    if (tx_underrun0) und0++;
    if (rx_overrun3)  ovr3++;
    if (tx_underrun3) und3++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push(input bit m3, input logic [7:0] d);
    tx_data = d;
    if (m3) tx_valid3 = 1'b1;
    else    tx_valid0 = 1'b1;
    wait_clk(1);
    tx_valid0 = 1'b0;
    tx_valid3 = 1'b0;
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
  endtask

  // Sends the top n bits of mo; mi collects poci as seen at each controller sample point.
  // rdy_end raises rx_ready for exactly the cycle in which the final bit completes the byte.
  task automatic spi_bits(input bit m3, input logic [7:0] mo, input int n, input bit rdy_end,
                          output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i >= 8 - n; i--) begin
      if (m3) sclk3 = 1'b0;
      pico = mo[i];
      wait_clk(4);
      mi[i] = m3 ? poci3 : poci0;
      if (m3) sclk3 = 1'b1;
      else    sclk0 = 1'b1;
      if (rdy_end && i == 0) begin
        wait_clk(2);
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
        wait_clk(1);
      end else begin
        wait_clk(4);
      end
      if (!m3) sclk0 = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    tests++;
    if ({busy0, poci_oe0, poci0, rx_valid0, tx_ready0, rx_overrun0, tx_underrun0} !== 7'b0000100)
    begin
      fails++;
      $display("FAIL reset_flags0: got %b expected 0000100",
               {busy0, poci_oe0, poci0, rx_valid0, tx_ready0, rx_overrun0, tx_underrun0});
    end
    tests++;
    if (rx_data0 !== 8'h00 || rx_data3 !== 8'h00) begin
      fails++;
      $display("FAIL reset_rx_data: got %h/%h expected 00/00", rx_data0, rx_data3);
    end
    wait_clk(3);
    reset = 1'b1;
    wait_clk(8);
    tests++;
    if ({busy3, poci_oe3, poci3, rx_valid3, tx_ready3} !== 5'b00001) begin
      fails++;
      $display("FAIL reset_flags3: got %b expected 00001",
               {busy3, poci_oe3, poci3, rx_valid3, tx_ready3});
    end
  endtask

  task automatic test_mode0();
    logic [7:0] mi;
    push(1'b0, 8'hA5);
    tests++;
    if (tx_ready0 !== 1'b0) begin
      fails++;
      $display("FAIL m0_hold_full: tx_ready got %b expected 0", tx_ready0);
    end
    cs0 = 1'b0;
    wait_clk(8);
    tests++;
    if ({busy0, poci_oe0, tx_ready0} !== 3'b111) begin
      fails++;
      $display("FAIL m0_select: busy/oe/tx_ready got %b expected 111",
               {busy0, poci_oe0, tx_ready0});
    end
    spi_bits(1'b0, 8'h3C, 8, 1'b0, mi);
    tests++;
    if (mi !== 8'hA5) begin
      fails++;
      $display("FAIL m0_poci: got %h expected a5", mi);
    end
    tests++;
    if (rx_data0 !== 8'h3C || rx_valid0 !== 1'b1) begin
      fails++;
      $display("FAIL m0_rx: got %h/%b expected 3c/1", rx_data0, rx_valid0);
    end
    wait_clk(4);
    cs0 = 1'b1;
    wait_clk(8);
    consume();
    tests++;
    if (busy0 !== 1'b0 || rx_valid0 !== 1'b0) begin
      fails++;
      $display("FAIL m0_release: busy/rx_valid got %b%b expected 00", busy0, rx_valid0);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] mi;
    int u0;
    u0 = und0;
    cs0 = 1'b0;
    wait_clk(8);
    tests++;
    if (und0 - u0 !== 1) begin
      fails++;
      $display("FAIL underrun_pulse: got %0d pulses expected 1", und0 - u0);
    end
    spi_bits(1'b0, 8'h00, 8, 1'b0, mi);
    tests++;
    if (mi !== 8'hFF) begin
      fails++;
      $display("FAIL underrun_default: got %h expected ff", mi);
    end
    wait_clk(4);
    cs0 = 1'b1;
    wait_clk(8);
    // tx_valid lands exactly in the SELECT cycle
    u0 = und0;
    cs0 = 1'b0;
    wait_clk(2);
    tx_data = 8'h12;
    tx_valid0 = 1'b1;
    wait_clk(1);
    tx_valid0 = 1'b0;
    wait_clk(5);
    tests++;
    if (und0 - u0 !== 0 || tx_ready0 !== 1'b1) begin
      fails++;
      $display("FAIL bypass_flags: underruns %0d tx_ready %b expected 0 and 1", und0 - u0,
               tx_ready0);
    end
    spi_bits(1'b0, 8'h00, 8, 1'b0, mi);
    tests++;
    if (mi !== 8'h12) begin
      fails++;
      $display("FAIL bypass_data: got %h expected 12", mi);
    end
    wait_clk(4);
    cs0 = 1'b1;
    wait_clk(8);
    consume();
  endtask

  task automatic test_overrun();
    logic [7:0] mi;
    int o0;
    cs0 = 1'b0;
    wait_clk(8);
    o0 = ovr0;
    spi_bits(1'b0, 8'h11, 8, 1'b0, mi);
    spi_bits(1'b0, 8'h22, 8, 1'b0, mi);
    tests++;
    if (rx_data0 !== 8'h22 || ovr0 - o0 !== 1) begin
      fails++;
      $display("FAIL overrun: rx_data %h pulses %0d expected 22 and 1", rx_data0, ovr0 - o0);
    end
    o0 = ovr0;
    spi_bits(1'b0, 8'h33, 8, 1'b1, mi);
    tests++;
    if (ovr0 - o0 !== 0 || rx_valid0 !== 1'b1 || rx_data0 !== 8'h33) begin
      fails++;
      $display("FAIL ready_on_complete: pulses %0d rx_valid %b rx_data %h expected 0 1 33",
               ovr0 - o0, rx_valid0, rx_data0);
    end
    wait_clk(4);
    cs0 = 1'b1;
    wait_clk(8);
    consume();
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    cs0 = 1'b0;
    wait_clk(8);
    spi_bits(1'b0, 8'hAB, 5, 1'b0, mi);
    wait_clk(4);
    cs0 = 1'b1;
    wait_clk(8);
    tests++;
    if ({rx_valid0, busy0, poci_oe0, poci0} !== 4'b0000) begin
      fails++;
      $display("FAIL abort_idle: rx_valid/busy/oe/poci got %b expected 0000",
               {rx_valid0, busy0, poci_oe0, poci0});
    end
    cs0 = 1'b0;
    wait_clk(8);
    spi_bits(1'b0, 8'hF0, 8, 1'b0, mi);
    tests++;
    if (rx_data0 !== 8'hF0 || rx_valid0 !== 1'b1) begin
      fails++;
      $display("FAIL abort_next_frame: got %h/%b expected f0/1", rx_data0, rx_valid0);
    end
    wait_clk(4);
    cs0 = 1'b1;
    wait_clk(8);
    consume();
  endtask

  task automatic test_reset_midframe();
    logic [7:0] mi;
    cs0 = 1'b0;
    wait_clk(8);
    push(1'b0, 8'h77);
    spi_bits(1'b0, 8'hFF, 3, 1'b0, mi);
    tests++;
    if (busy0 !== 1'b1 || tx_ready0 !== 1'b0 || rx_data0 !== 8'hF0) begin
      fails++;
      $display("FAIL pre_reset: busy %b tx_ready %b rx_data %h expected 1 0 f0", busy0,
               tx_ready0, rx_data0);
    end
    #1;
    reset = 1'b0;
    #1;
    tests++;
    if ({busy0, poci_oe0, poci0, rx_valid0, tx_ready0, rx_overrun0, tx_underrun0} !== 7'b0000100
        || rx_data0 !== 8'h00) begin
      fails++;
      $display("FAIL midframe_reset: flags %b rx_data %h expected 0000100 00",
               {busy0, poci_oe0, poci0, rx_valid0, tx_ready0, rx_overrun0, tx_underrun0},
               rx_data0);
    end
    wait_clk(2);
    reset = 1'b1;
    wait_clk(8);
    spi_bits(1'b0, 8'hFF, 8, 1'b0, mi);
    tests++;
    if ({busy0, rx_valid0, poci0} !== 3'b000) begin
      fails++;
      $display("FAIL ignore_after_reset: busy/rx_valid/poci got %b expected 000",
               {busy0, rx_valid0, poci0});
    end
    cs0 = 1'b1;
    wait_clk(8);
    cs0 = 1'b0;
    wait_clk(8);
    tests++;
    if (busy0 !== 1'b1) begin
      fails++;
      $display("FAIL reselect: busy got %b expected 1", busy0);
    end
    spi_bits(1'b0, 8'h96, 8, 1'b0, mi);
    tests++;
    if (rx_data0 !== 8'h96 || mi !== 8'hFF) begin
      fails++;
      $display("FAIL post_reset_frame: rx %h poci %h expected 96 ff", rx_data0, mi);
    end
    wait_clk(4);
    cs0 = 1'b1;
    wait_clk(8);
    consume();
  endtask

  task automatic test_back_to_back();
    logic [7:0] mi;
    int u3;
    push(1'b1, 8'h5A);
    u3 = und3;
    cs3 = 1'b0;
    wait_clk(8);
    tests++;
    if ({busy3, poci_oe3, tx_ready3} !== 3'b111) begin
      fails++;
      $display("FAIL m3_select: busy/oe/tx_ready got %b expected 111",
               {busy3, poci_oe3, tx_ready3});
    end
    push(1'b1, 8'hC3);
    spi_bits(1'b1, 8'h01, 8, 1'b0, mi);
    tests++;
    if (mi !== 8'h5A || rx_data3 !== 8'h01 || rx_valid3 !== 1'b1) begin
      fails++;
      $display("FAIL m3_byte1: poci %h rx %h/%b expected 5a 01/1", mi, rx_data3, rx_valid3);
    end
    consume();
    tests++;
    if (rx_valid3 !== 1'b0) begin
      fails++;
      $display("FAIL m3_consume: rx_valid got %b expected 0", rx_valid3);
    end
    spi_bits(1'b1, 8'h80, 8, 1'b0, mi);
    tests++;
    if (mi !== 8'hC3 || rx_data3 !== 8'h80 || rx_valid3 !== 1'b1) begin
      fails++;
      $display("FAIL m3_byte2: poci %h rx %h/%b expected c3 80/1", mi, rx_data3, rx_valid3);
    end
    wait_clk(4);
    cs3 = 1'b1;
    wait_clk(8);
    tests++;
    if (busy3 !== 1'b0 || ovr3 !== 0 || und3 - u3 !== 1) begin
      fails++;
      $display("FAIL m3_end: busy %b overruns %0d underruns %0d expected 0 0 1", busy3, ovr3,
               und3 - u3);
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_underrun();
    test_overrun();
    test_abort();
    test_reset_midframe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
